// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between instruction fetch and load/store; data wins ties, grants alternate on ack.
// Latency: request to bus_req 1 cycle; ack/rdata are combinational from bus_ack. Optional watchdog: MEM_ARB_TIMEOUT_EN.
// Backpressure: masters hold req (stall_* high) until their ack; bus fields held stable until bus_ack.
module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_ack,
  output logic              inst_err,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [3:0]        data_sel,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ack,
  output logic              data_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              stall_if,
  output logic              stall_mem
);

  typedef enum logic [1:0] {IDLE, INST, DATA} state_t;

  state_t              state, state_nxt;
  logic                last_data, last_data_nxt;
  logic                load, load_data;
  logic                busy, done, tmo;
  logic                bus_req_nxt, bus_we_nxt;
  logic [3:0]          bus_sel_nxt;
  logic [ADDR_W-1:0]   bus_addr_nxt;
  logic [DATA_W-1:0]   bus_wdata_nxt;

  assign busy = (state == INST) || (state == DATA);
  assign done = busy && (bus_ack || tmo);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;

  // A real bus_ack in the limit cycle takes precedence over the watchdog.
  assign tmo = busy && !bus_ack && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (load)
      cnt <= '0;
    else if (busy && !bus_ack)
      cnt <= cnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    load      = 1'b0;
    load_data = 1'b0;
    case (state)
      IDLE: begin
        if (data_req) begin
          load      = 1'b1;
          load_data = 1'b1;
        end else if (inst_req) begin
          load = 1'b1;
        end
      end
      INST, DATA: begin
        // On completion only the other master may be granted; the acked one is ignored this cycle.
        if (done) begin
          if (last_data) begin
            load = inst_req;
          end else if (data_req) begin
            load      = 1'b1;
            load_data = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    last_data_nxt = last_data;
    bus_req_nxt   = bus_req;
    bus_we_nxt    = bus_we;
    bus_sel_nxt   = bus_sel;
    bus_addr_nxt  = bus_addr;
    bus_wdata_nxt = bus_wdata;
    if (load) begin
      state_nxt     = load_data ? DATA : INST;
      last_data_nxt = load_data;
      bus_req_nxt   = 1'b1;
      bus_we_nxt    = load_data & data_we;
      bus_sel_nxt   = load_data ? data_sel : 4'hF;
      bus_addr_nxt  = load_data ? data_addr : inst_addr;
      bus_wdata_nxt = load_data ? data_wdata : '0;
    end else if (done || !busy) begin
      state_nxt     = IDLE;
      bus_req_nxt   = 1'b0;
      bus_we_nxt    = 1'b0;
      bus_sel_nxt   = '0;
      bus_addr_nxt  = '0;
      bus_wdata_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_data <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      state     <= state_nxt;
      last_data <= last_data_nxt;
      bus_req   <= bus_req_nxt;
      bus_we    <= bus_we_nxt;
      bus_sel   <= bus_sel_nxt;
      bus_addr  <= bus_addr_nxt;
      bus_wdata <= bus_wdata_nxt;
    end
  end

  assign inst_ack   = (state == INST) && done;
  assign data_ack   = (state == DATA) && done;
  assign inst_err   = (state == INST) && tmo;
  assign data_err   = (state == DATA) && tmo;
  assign inst_rdata = ((state == INST) && bus_ack) ? bus_rdata : '0;
  assign data_rdata = ((state == DATA) && bus_ack) ? bus_rdata : '0;
  assign stall_if   = inst_req & ~inst_ack;
  assign stall_mem  = data_req & ~data_ack;

  // Masters must hold their request until acknowledged.
  assert property (@(posedge clk) disable iff (!rst) (inst_req && !inst_ack) |=> inst_req);
  assert property (@(posedge clk) disable iff (!rst) (data_req && !data_ack) |=> data_req);
  assert property (@(posedge clk) TIMEOUT_CYCLES >= 2);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter plus hand sequences for reset abort and watchdog.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req, data_we, bus_ack;
  logic [31:0] inst_addr, data_addr, data_wdata, bus_rdata;
  logic [3:0]  data_sel;
  logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata;
  logic        inst_ack, inst_err, data_ack, data_err;
  logic        bus_req, bus_we, stall_if, stall_mem;
  logic [3:0]  bus_sel;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_ack(inst_ack), .inst_err(inst_err),
    .data_req(data_req), .data_we(data_we), .data_sel(data_sel), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ack(data_ack), .data_err(data_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  typedef struct {
    logic        ir;   logic [31:0] ia;
    logic        dr;   logic        dwe;  logic [3:0] dsel; logic [31:0] da; logic [31:0] dwd;
    logic        ba;   logic [31:0] brd;
    logic        ebr;  logic        ebwe; logic [3:0] ebsel; logic [31:0] eba; logic [31:0] ebwd;
    logic        eia;  logic [31:0] eird; logic       eda;   logic [31:0] edrd;
    logic        esi;  logic        esm;
  } vec_t;

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia,
    input logic dr, input logic dwe, input logic [3:0] dsel, input logic [31:0] da, input logic [31:0] dwd,
    input logic ba, input logic [31:0] brd,
    input logic ebr, input logic ebwe, input logic [3:0] ebsel, input logic [31:0] eba, input logic [31:0] ebwd,
    input logic eia, input logic [31:0] eird, input logic eda, input logic [31:0] edrd,
    input logic esi, input logic esm);
    vec_t v;
    v.ir = ir;   v.ia = ia;   v.dr = dr;   v.dwe = dwe;   v.dsel = dsel; v.da = da; v.dwd = dwd;
    v.ba = ba;   v.brd = brd; v.ebr = ebr; v.ebwe = ebwe; v.ebsel = ebsel; v.eba = eba; v.ebwd = ebwd;
    v.eia = eia; v.eird = eird; v.eda = eda; v.edrd = edrd; v.esi = esi; v.esm = esm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_addr = 0; data_req = 0; data_we = 0; data_sel = 0;
    data_addr = 0; data_wdata = 0; bus_ack = 0; bus_rdata = 0;
  endtask

  localparam int NV = 17;
  vec_t vec [NV];

  initial begin
    // fetch with 2-cycle memory, write/fetch priority, D,I,D,I,D fairness, ack while idle
    vec[0]  = mk(1,'h100, 0,0,4'h0,0,0,      0,0,          0,0,4'h0,0,0,        0,0,0,0,                    1,0);
    vec[1]  = mk(1,'h100, 0,0,4'h0,0,0,      0,0,          1,0,4'hF,'h100,0,    0,0,0,0,                    1,0);
    vec[2]  = mk(1,'h100, 0,0,4'h0,0,0,      0,0,          1,0,4'hF,'h100,0,    0,0,0,0,                    1,0);
    vec[3]  = mk(1,'h100, 0,0,4'h0,0,0,      1,'h34020020, 1,0,4'hF,'h100,0,    1,'h34020020,0,0,           0,0);
    vec[4]  = mk(0,0,     0,0,4'h0,0,0,      0,0,          0,0,4'h0,0,0,        0,0,0,0,                    0,0);
    vec[5]  = mk(1,'h104, 1,1,4'h3,'h80,'hBEEF, 0,0,       0,0,4'h0,0,0,        0,0,0,0,                    1,1);
    vec[6]  = mk(1,'h104, 1,1,4'h3,'h80,'hBEEF, 1,'h11111111, 1,1,4'h3,'h80,'hBEEF, 0,0,1,'h11111111,     1,0);
    vec[7]  = mk(1,'h104, 0,0,4'h0,0,0,      1,'h22222222, 1,0,4'hF,'h104,0,    1,'h22222222,0,0,           0,0);
    vec[8]  = mk(1,'h200, 1,0,4'hF,'h300,0,  0,0,          0,0,4'h0,0,0,        0,0,0,0,                    1,1);
    vec[9]  = mk(1,'h200, 1,0,4'hF,'h300,0,  1,'hD0000001, 1,0,4'hF,'h300,0,    0,0,1,'hD0000001,           1,0);
    vec[10] = mk(1,'h200, 1,0,4'hF,'h304,0,  1,'h10000001, 1,0,4'hF,'h200,0,    1,'h10000001,0,0,           0,1);
    vec[11] = mk(1,'h204, 1,0,4'hF,'h304,0,  1,'hD0000002, 1,0,4'hF,'h304,0,    0,0,1,'hD0000002,           1,0);
    vec[12] = mk(1,'h204, 1,0,4'hF,'h308,0,  1,'h10000002, 1,0,4'hF,'h204,0,    1,'h10000002,0,0,           0,1);
    vec[13] = mk(0,0,     1,0,4'hF,'h308,0,  1,'hD0000003, 1,0,4'hF,'h308,0,    0,0,1,'hD0000003,           0,0);
    vec[14] = mk(1,'h400, 0,0,4'h0,0,0,      1,'h55555555, 0,0,4'h0,0,0,        0,0,0,0,                    1,0);
    vec[15] = mk(1,'h400, 0,0,4'h0,0,0,      1,'h66666666, 1,0,4'hF,'h400,0,    1,'h66666666,0,0,           0,0);
    vec[16] = mk(0,0,     0,0,4'h0,0,0,      0,0,          0,0,4'h0,0,0,        0,0,0,0,                    0,0);

    clear_inputs();
    rst = 0;
    #12;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_sel", bus_sel, 0);
    chk("rst_inst_ack", inst_ack, 0);
    chk("rst_data_ack", data_ack, 0);
    chk("rst_stall_if", stall_if, 0);
    chk("rst_stall_mem", stall_mem, 0);
    @(negedge clk);
    rst = 1;

    for (int i = 0; i < NV; i++) begin
      tick();
      inst_req = vec[i].ir;  inst_addr = vec[i].ia;
      data_req = vec[i].dr;  data_we = vec[i].dwe; data_sel = vec[i].dsel;
      data_addr = vec[i].da; data_wdata = vec[i].dwd;
      bus_ack = vec[i].ba;   bus_rdata = vec[i].brd;
      #1;
      chk($sformatf("v%0d_bus_req", i),    bus_req,    vec[i].ebr);
      chk($sformatf("v%0d_bus_we", i),     bus_we,     vec[i].ebwe);
      chk($sformatf("v%0d_bus_sel", i),    bus_sel,    vec[i].ebsel);
      chk($sformatf("v%0d_bus_addr", i),   bus_addr,   vec[i].eba);
      chk($sformatf("v%0d_bus_wdata", i),  bus_wdata,  vec[i].ebwd);
      chk($sformatf("v%0d_inst_ack", i),   inst_ack,   vec[i].eia);
      chk($sformatf("v%0d_inst_rdata", i), inst_rdata, vec[i].eird);
      chk($sformatf("v%0d_data_ack", i),   data_ack,   vec[i].eda);
      chk($sformatf("v%0d_data_rdata", i), data_rdata, vec[i].edrd);
      chk($sformatf("v%0d_stall_if", i),   stall_if,   vec[i].esi);
      chk($sformatf("v%0d_stall_mem", i),  stall_mem,  vec[i].esm);
      chk($sformatf("v%0d_errs", i),       {inst_err, data_err}, 0);
    end

    // Reset asserted in the middle of a store transfer
    tick();
    data_req = 1; data_we = 1; data_sel = 4'hF; data_addr = 'h40; data_wdata = 'h1234;
    tick();
    #1;
    chk("t1_pre_bus_req", bus_req, 1);
    chk("t1_pre_bus_addr", bus_addr, 'h40);
    #2;
    rst = 0;
    #1;
    chk("t1_bus_req", bus_req, 0);
    chk("t1_bus_we", bus_we, 0);
    chk("t1_bus_addr", bus_addr, 0);
    chk("t1_bus_wdata", bus_wdata, 0);
    chk("t1_acks", {inst_ack, data_ack}, 0);
    chk("t1_stall_mem_req", stall_mem, 1);
    chk("t1_stall_if", stall_if, 0);
    data_req = 0;
    #1;
    chk("t1_stall_mem_noreq", stall_mem, 0);
    @(negedge clk);
    rst = 1;
    clear_inputs();
    tick();
    #1;
    chk("t1_post_idle", bus_req, 0);
    inst_req = 1; inst_addr = 'h700;
    tick();
    #1;
    chk("t1_post_grant_req", bus_req, 1);
    chk("t1_post_grant_addr", bus_addr, 'h700);
    chk("t1_post_grant_sel", bus_sel, 4'hF);
    bus_ack = 1; bus_rdata = 'hA5A5A5A5;
    #1;
    chk("t1_post_inst_ack", inst_ack, 1);
    chk("t1_post_inst_rdata", inst_rdata, 'hA5A5A5A5);
    tick();
    clear_inputs();

    // Load that memory never acknowledges, with a fetch waiting behind it
    tick();
    data_req = 1; data_we = 0; data_sel = 4'hF; data_addr = 'h500;
    inst_req = 1; inst_addr = 'h600;
    bus_rdata = 'hDEADBEEF;
    for (int c = 1; c <= 8; c++) begin
      logic exp_to;
`ifdef MEM_ARB_TIMEOUT_EN
      exp_to = (c == 8);
`else
      exp_to = 1'b0;
`endif
      tick();
      #1;
      chk($sformatf("t6_c%0d_bus_req", c), bus_req, 1);
      chk($sformatf("t6_c%0d_bus_addr", c), bus_addr, 'h500);
      chk($sformatf("t6_c%0d_data_ack", c), data_ack, exp_to);
      chk($sformatf("t6_c%0d_data_err", c), data_err, exp_to);
      chk($sformatf("t6_c%0d_data_rdata", c), data_rdata, 0);
      chk($sformatf("t6_c%0d_inst_err", c), inst_err, 0);
    end
    tick();
`ifdef MEM_ARB_TIMEOUT_EN
    data_req = 0;
    #1;
    chk("t6_next_bus_req", bus_req, 1);
    chk("t6_next_bus_addr", bus_addr, 'h600);
`else
    #1;
    chk("t6_wait_bus_addr", bus_addr, 'h500);
    chk("t6_wait_data_ack", data_ack, 0);
    bus_ack = 1;
    #1;
    chk("t6_late_data_ack", data_ack, 1);
    chk("t6_late_data_err", data_err, 0);
    chk("t6_late_data_rdata", data_rdata, 'hDEADBEEF);
    tick();
    data_req = 0;
    #1;
    chk("t6_next_bus_addr", bus_addr, 'h600);
`endif
    bus_ack = 1;
    #1;
    chk("t6_inst_ack", inst_ack, 1);
    chk("t6_inst_err", inst_err, 0);
    chk("t6_inst_rdata", inst_rdata, 'hDEADBEEF);
    tick();
    clear_inputs();
    tick();
    #1;
    chk("t6_final_idle", bus_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
